// File: rtl/led_segment_scan.sv
// Multiplexed seven-segment scanner for 74HC595-chained display boards.
// Double-buffered digit data, round-robin scan of enabled digits, 16-bit serial word per slot.
module led_segment_scan #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCLK_DIV       = 2,
  parameter int unsigned SLOT_CYCLES    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   seg_data,
  input  logic [DIGITS-1:0]     seg_data_en,
  input  logic [DIGITS-1:0]     seg_dot_en,
  output logic                  rclk_out,
  output logic                  sclk_out,
  output logic                  sdio_out,
  output logic [2:0]            cur_digit,
  output logic                  frame_done
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, HOLD} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] en;
    logic [DIGITS-1:0] dot;
  } buf_t;

  state_t            state_q, state_d;
  logic              arm_q, arm_d;
  logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              phase_q, phase_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       word_q, word_d;
  buf_t              act_q, act_d, pend_q, pend_d;
  logic              sclk_d, rclk_d, sdio_d, fd_d;
  logic [2:0]        cur_d;

  logic              slot_start;
  logic [3:0]        pick_act, pick_pend;
  logic              wrap, sel_found;
  logic [2:0]        sel_idx;
  buf_t              src;
  logic [31:0]       data32;
  logic [7:0]        dot8, seg, dsel;
  logic [3:0]        nib;
  logic [15:0]       word;

  // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Returns {found, index}: first enabled digit from 0, or the next one after 'from' with wrap.
  function automatic logic [3:0] pick(input logic [DIGITS-1:0] en, input logic [2:0] from,
                                      input logic from_zero);
    logic [7:0]  en8;
    logic        found;
    logic [2:0]  idx;
    int unsigned j;
    en8   = 8'(en);
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      j = from_zero ? i : (32'(from) + i + 32'd1) % DIGITS;
      if (!found && en8[3'(j)]) begin
        found = 1'b1;
        idx   = 3'(j);
      end
    end
    return {found, idx};
  endfunction

  // Next slot's digit and word; a wrap starts a new frame from the pending buffer.
  always_comb begin
    pick_act  = pick(act_q.en, cur_digit, 1'b0);
    pick_pend = pick(pend_q.en, 3'd0, 1'b1);
    wrap      = !pick_act[3] || (pick_act[2:0] <= cur_digit);
    src       = wrap ? pend_q : act_q;
    sel_found = wrap ? pick_pend[3] : 1'b1;
    sel_idx   = wrap ? pick_pend[2:0] : pick_act[2:0];
    data32    = 32'(src.data);
    dot8      = 8'(src.dot);
    nib       = 4'(data32 >> {sel_idx, 2'b00});
    seg       = sel_found ? {dot8[sel_idx], decode(nib)} : 8'h00;
    dsel      = sel_found ? (8'd1 << sel_idx) : 8'h00;
    word      = {seg ^ {8{SEG_ACTIVE_LOW}}, dsel ^ {8{DIG_ACTIVE_LOW}}};
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    slot_cnt_d = slot_cnt_q + CNT_W'(1);
    div_d      = div_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    word_d     = word_q;
    sclk_d     = sclk_out;
    rclk_d     = rclk_out;
    sdio_d     = sdio_out;
    cur_d      = cur_digit;
    fd_d       = 1'b0;
    act_d      = act_q;
    pend_d     = load ? buf_t'({seg_data, seg_data_en, seg_dot_en}) : pend_q;
    slot_start = 1'b0;

    case (state_q)
      IDLE: begin
        slot_cnt_d = '0;
        arm_d      = 1'b1;
        slot_start = arm_q;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else if (bit_q == 4'd15) begin
            state_d = LATCH;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            rclk_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            word_d  = {word_q[14:0], 1'b0};
            sdio_d  = word_q[14];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          rclk_d  = 1'b0;
          state_d = HOLD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        sclk_d     = 1'b0;
        rclk_d     = 1'b0;
        slot_start = (slot_cnt_q == CNT_LAST);
      end
      default: state_d = IDLE;
    endcase

    if (slot_start) begin
      state_d    = SHIFT;
      slot_cnt_d = '0;
      div_d      = '0;
      phase_d    = 1'b0;
      bit_d      = 4'd0;
      word_d     = word;
      sdio_d     = word[15];
      sclk_d     = 1'b0;
      rclk_d     = 1'b0;
      cur_d      = sel_idx;
      fd_d       = wrap;
      if (wrap) act_d = pend_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      slot_cnt_q <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= 4'd0;
      word_q     <= 16'h0000;
      act_q      <= '0;
      pend_q     <= '0;
      sclk_out   <= 1'b0;
      rclk_out   <= 1'b0;
      sdio_out   <= 1'b0;
      cur_digit  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      slot_cnt_q <= slot_cnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      sclk_out   <= sclk_d;
      rclk_out   <= rclk_d;
      sdio_out   <= sdio_d;
      cur_digit  <= cur_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: doc/led_segment_scan.md
# led_segment_scan

Parametrised multiplexed seven-segment driver for the 74HC595-chained display boards. It is the successor to the fixed 8-digit driver and sits between the calculator datapath and the display connector. It accepts hex nibbles, a per-digit enable and a per-digit dot enable through a double-buffered load interface. It time-multiplexes only the enabled digits, serialising one 16-bit segment/select word per slot onto RCK/SCK/SER, and reports frame completion.

## Interface
- DIGITS, 8: number of digits scanned, 1..8; the select byte is always 8 bits wide and unused bits stay inactive.
- SCLK_DIV, 2: system clocks per SCK half-period, ≥1.
- SLOT_CYCLES, 50000: system clocks per digit slot, ≥ 34*SCLK_DIV+1.
- SEG_ACTIVE_LOW, 1: 1 inverts the segment byte (common-anode).
- DIG_ACTIVE_LOW, 0: 1 inverts the select byte.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe that captures the three data inputs into the pending buffer.
- seg_data  in  4*DIGITS  nibble d at [4d+3:4d]; digit 0 = rightmost.
- seg_data_en  in  DIGITS  bit d = 1 enables digit d.
- seg_dot_en  in  DIGITS  bit d = 1 lights the dp of digit d.
- rclk_out  out  1  74HC595 RCK.
- sclk_out  out  1  74HC595 SCK.
- sdio_out  out  1  74HC595 SER.
- cur_digit  out  3  index of the digit in the current slot.
- frame_done  out  1  one-cycle pulse at the frame boundary.

## Operation
- Buffers: `load` writes the pending buffer on that edge. Pending copies to the active buffer only at a frame boundary. If `load` coincides with a boundary, active takes the old pending contents and the new data appears one frame later. Reset clears both buffers, so all digits are disabled.
- Decode (active-high {dp,g,f,e,d,c,b,a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. dp = seg_dot_en[d]. Polarity parameters are applied after decode.
- Word: [15:8] = segment byte, [7:0] = one-hot select of digit d. Shifted MSB first.
- Digit selection at each slot start:
  - Take the next enabled index after cur_digit in round-robin order, wrapping above DIGITS-1.
  - Disabled digits get no slot, so k enabled digits get a 1/k duty cycle.
  - A frame boundary occurs when the selection wraps, i.e. the new index ≤ previous. With exactly one enabled digit, every slot is a boundary.
  - If no digit is enabled: cur_digit = 0, and the word is the blank pattern (segments off, all selects inactive, with polarity applied). Every slot is then a boundary.
- FSM: IDLE → SHIFT → LATCH → HOLD → SHIFT.
  - IDLE exists only after reset, for one cycle.
  - SHIFT: 16 bits, each bit being SCK low for SCLK_DIV cycles then high for SCLK_DIV cycles. SER is updated on entry to the low phase.
  - LATCH: RCK high for SCLK_DIV cycles, SCK low.
  - HOLD: all outputs low except SER, which holds its last bit. HOLD lasts until the slot counter reaches SLOT_CYCLES-1.
- Mid-operation reset forces IDLE immediately. Any partial word is abandoned and the 595 latches keep their previous contents.

## Timing
- Reset values: rclk_out=0, sclk_out=0, sdio_out=0, cur_digit=0, frame_done=0; slot counter = 0.
- First slot begins on the second rising edge after rst_n deasserts.
- Per slot, from slot start:
  - SCK rising edge of bit i at cycle (2i+1)*SCLK_DIV.
  - RCK high during cycles 32*SCLK_DIV .. 33*SCLK_DIV-1.
  - Next slot starts at cycle SLOT_CYCLES.
- frame_done is high in the first cycle of a boundary slot; the buffer transfer happens on the same edge.
- Latency from `load` to display: the remaining part of the current frame, plus the next whole frame when the load hits a boundary cycle.

## Test plan
- Reset, then load seg_data=0x08754321 (nibble 7..0 = 0,8,7,5,4,3,2,1), en=8'hFD, dot=0, with SCLK_DIV=1 and SLOT_CYCLES=40. Required:
  - Words 0xF901, then 0xB004, 0x9908 … (digit 1 skipped).
  - cur_digit sequence 0,2,3,4,5,6,7, then wrap with frame_done=1.
- dot=8'h01, en=8'h01: every slot is word 0x7901; frame_done pulses every 40 cycles.
- en=0 after reset: every word is 0xFF00 and cur_digit stays 0.
- load asserted in a frame_done cycle: the old pending value displays for one full frame, then the new value.
- rst_n pulsed low during SHIFT bit 5: all outputs 0 within the same cycle; after release the first SCK rising edge is SCLK_DIV cycles after the second edge.
- DIGITS=4, SCLK_DIV=3: SCK period is 6 clocks, RCK width 3; select byte bits [7:4] stay 0.
